// File: rtl/char_ram_16x16_gra_if.sv
// Cursor-based text write port of the 16x16 character buffer.
interface char_ram_16x16_gra_if;
   logic       wr_valid;
   logic       wr_ready;
   logic [6:0] wr_char;
   logic       wr_set_cursor;
   logic [7:0] wr_addr;

   modport master (
      output wr_valid,
      output wr_char,
      output wr_set_cursor,
      output wr_addr,
      input  wr_ready
   );

   modport slave (
      input  wr_valid,
      input  wr_char,
      input  wr_set_cursor,
      input  wr_addr,
      output wr_ready
   );
endinterface

// File: rtl/char_ram_16x16_gra.sv
// Writable 16x16 character buffer for the text overlay, with a self-clearing
// fill FSM and a cursor-based write port.
module char_ram_16x16_gra #(
   parameter logic [6:0] CLEAR_CHAR = 7'h20,
   parameter logic [6:0] NL_CHAR    = 7'h0A
) (
   input  logic                        clk,
   input  logic                        rst,
   char_ram_16x16_gra_if.slave         wr,
   input  logic [7:0]                  char_xy,
   output logic [6:0]                  char_code,
   input  logic                        clr_req,
   output logic                        busy,
   output logic [7:0]                  cursor
);

   typedef enum logic {CLEAR, IDLE} state_t;

   state_t     state;
   logic [7:0] clr_ptr;
   logic [6:0] mem [256];

   logic       accept;
   logic       mem_we;
   logic [7:0] mem_addr;
   logic [6:0] mem_din;

   assign wr.wr_ready = (state == IDLE) && !clr_req;
   assign accept      = wr.wr_valid && wr.wr_ready;

   // Stale cells are masked while the clear sweep is in progress.
   assign char_code = (state == CLEAR) ? CLEAR_CHAR : mem[char_xy];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= CLEAR;
         clr_ptr <= '0;
         cursor  <= '0;
         busy    <= 1'b1;
      end else begin
         case (state)
            CLEAR: begin
               clr_ptr <= clr_ptr + 8'd1;
               if (clr_ptr == 8'hFF) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            IDLE: begin
               if (clr_req) begin
                  state   <= CLEAR;
                  clr_ptr <= '0;
                  cursor  <= '0;
                  busy    <= 1'b1;
               end else if (accept) begin
                  if (wr.wr_set_cursor)
                     cursor <= wr.wr_addr;
                  else if (wr.wr_char == NL_CHAR)
                     cursor <= {cursor[7:4] + 4'd1, 4'h0};
                  else
                     cursor <= cursor + 8'd1;
               end
            end
            default: begin
               state <= CLEAR;
               busy  <= 1'b1;
            end
         endcase
      end
   end

   always_comb begin
      mem_we   = 1'b0;
      mem_addr = clr_ptr;
      mem_din  = CLEAR_CHAR;
      if (state == CLEAR) begin
         mem_we = 1'b1;
      end else if (accept && !wr.wr_set_cursor && (wr.wr_char != NL_CHAR)) begin
         mem_we   = 1'b1;
         mem_addr = cursor;
         mem_din  = wr.wr_char;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we)
         mem[mem_addr] <= mem_din;
   end

endmodule

// File: tb/tb_char_ram_16x16_gra.sv
// Scoreboard bench for char_ram_16x16_gra against an array/cursor reference model.
module tb_char_ram_16x16_gra;

   localparam int KCODE = 0;
   localparam int KCUR  = 1;
   localparam int KBUSY = 2;
   localparam int KRDY  = 3;

   typedef struct {
      int cyc;
      int kind;
      int val;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] char_xy = '0;
   logic [6:0] char_code;
   logic       clr_req = 1'b0;
   logic       busy;
   logic [7:0] cursor;

   char_ram_16x16_gra_if bus ();

   char_ram_16x16_gra #(.CLEAR_CHAR(7'h20), .NL_CHAR(7'h0A)) dut (
      .clk       (clk),
      .rst       (rst),
      .wr        (bus),
      .char_xy   (char_xy),
      .char_code (char_code),
      .clr_req   (clr_req),
      .busy      (busy),
      .cursor    (cursor)
   );

   always #5 clk = ~clk;

   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t q[$];

   int   model_mem [256];
   int   model_cur;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: compares everything scheduled for the current cycle.
   always @(negedge clk) begin
      exp_t  e;
      int    act;
      string nm;
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         e = q.pop_front();
         case (e.kind)
            KCODE:   begin act = int'(char_code);   nm = "char_code"; end
            KCUR:    begin act = int'(cursor);      nm = "cursor";    end
            KBUSY:   begin act = int'(busy);        nm = "busy";      end
            default: begin act = int'(bus.wr_ready); nm = "wr_ready"; end
         endcase
         checks++;
         if (act !== e.val) begin
            errors++;
            $display("FAIL %s cyc=%0d xy=%h actual=%h expected=%h",
                     nm, cyc, char_xy, act, e.val);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic push(input int k, input int v);
      q.push_back(exp_t'{cyc, k, v});
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_clear(input int pulse_at, input int abort_at);
      for (int i = 0; i < 256; i++) begin
         if (i == abort_at) begin
            clr_req = 1'b0;
            return;
         end
         clr_req = (i == pulse_at);
         char_xy = 8'($urandom);
         push(KCODE, 32'h20);
         push(KBUSY, 1);
         push(KRDY, 0);
         step();
      end
      clr_req = 1'b0;
      for (int a = 0; a < 256; a++) model_mem[a] = 32'h20;
      model_cur = 0;
      push(KBUSY, 0);
      push(KRDY, 1);
      push(KCUR, 0);
   endtask

   task automatic rd(input int a);
      char_xy = 8'(a);
      push(KCODE, model_mem[a]);
      step();
   endtask

   task automatic sweep();
      for (int a = 0; a < 256; a++) rd(a);
   endtask

   task automatic set_cur(input int a);
      bus.wr_valid      = 1'b1;
      bus.wr_set_cursor = 1'b1;
      bus.wr_addr       = 8'(a);
      push(KRDY, 1);
      step();
      model_cur = a;
      bus.wr_valid      = 1'b0;
      bus.wr_set_cursor = 1'b0;
   endtask

   task automatic do_write(input int ch);
      bus.wr_valid      = 1'b1;
      bus.wr_set_cursor = 1'b0;
      bus.wr_char       = 7'(ch);
      push(KRDY, 1);
      step();
      if (ch == 32'h0A) begin
         model_cur = ((model_cur / 16 + 1) % 16) * 16;
      end else begin
         model_mem[model_cur] = ch;
         model_cur = (model_cur + 1) % 256;
      end
      bus.wr_valid = 1'b0;
   endtask

   task automatic chk_cur();
      push(KCUR, model_cur);
      step();
   endtask

   initial begin
      int score [5] = '{32'h53, 32'h43, 32'h4F, 32'h52, 32'h45};
      bus.wr_valid      = 1'b1;
      bus.wr_set_cursor = 1'b1;
      bus.wr_addr       = 8'h00;
      bus.wr_char       = 7'h00;
      model_cur         = 0;
      for (int a = 0; a < 256; a++) model_mem[a] = 0;

      // Reset held: clearing, not ready, masked read
      for (int i = 0; i < 3; i++) begin
         char_xy = 8'($urandom);
         push(KBUSY, 1);
         push(KRDY, 0);
         push(KCODE, 32'h20);
         push(KCUR, 0);
         step();
      end
      rst = 1'b1;
      run_clear(-1, -1);
      bus.wr_valid      = 1'b0;
      bus.wr_set_cursor = 1'b0;
      step();
      sweep();

      // SCORE at 0x12
      set_cur(32'h12);
      for (int i = 0; i < 5; i++) do_write(score[i]);
      chk_cur();
      for (int a = 32'h12; a <= 32'h16; a++) rd(a);

      // Wrap at end of buffer
      set_cur(32'hFE);
      do_write(32'h41);
      do_write(32'h42);
      do_write(32'h43);
      chk_cur();
      rd(32'hFE); rd(32'hFF); rd(32'h00);

      // Newlines
      set_cur(32'h35);
      do_write(32'h0A);
      chk_cur();
      rd(32'h35);
      set_cur(32'hF7);
      do_write(32'h0A);
      chk_cur();

      // Randomized mix of writes, cursor loads and reads
      for (int n = 0; n < 200; n++) begin
         case ($urandom_range(0, 5))
            0:       set_cur(int'($urandom_range(0, 255)));
            1:       do_write(32'h0A);
            2, 3:    do_write(int'($urandom_range(0, 127)));
            4:       chk_cur();
            default: rd(int'($urandom_range(0, 255)));
         endcase
      end
      sweep();

      // clr_req with simultaneous write: write refused, clear ignores a mid-clear pulse
      bus.wr_valid      = 1'b1;
      bus.wr_set_cursor = 1'b0;
      bus.wr_char       = 7'h55;
      clr_req           = 1'b1;
      push(KRDY, 0);
      step();
      clr_req      = 1'b0;
      bus.wr_valid = 1'b0;
      run_clear(100, -1);
      step();
      sweep();

      // Reset asserted at clear cycle 100 restarts the full clear
      set_cur(32'h80);
      for (int i = 0; i < 8; i++) do_write(int'($urandom_range(32'h41, 32'h5A)));
      clr_req = 1'b1;
      step();
      clr_req = 1'b0;
      run_clear(-1, 100);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         char_xy = 8'($urandom);
         push(KBUSY, 1);
         push(KRDY, 0);
         push(KCODE, 32'h20);
         push(KCUR, 0);
         step();
      end
      rst = 1'b1;
      run_clear(-1, -1);
      step();
      sweep();

      step();
      step();
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain actual=%0d expected=0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/char_ram_16x16_gra.md
Name: char_ram_16x16_gra

Overview:
- Writable 16x16 character buffer.
- Replaces the fixed character ROM feeding the game-screen text overlay: the rectangle-char drawer supplies char_xy and gets char_code back, and game logic writes text through a cursor-based valid/ready port.
- Adds a self-clearing fill FSM, so the screen text can change at run time (score, messages) without new ROM images.

Parameters:
- CLEAR_CHAR, 7'h20, code written to every cell during clear and returned while clearing.
- NL_CHAR, 7'h0A, newline control code; moves cursor, writes nothing.

Ports:
- clk  input  1  system clock (VGA pixel clock domain)
- rst  input  1  asynchronous, active-low reset
- char_xy  input  8  read address {row[7:4], col[3:0]} from overlay drawer
- char_code  output  7  character code at char_xy, combinational
- wr_valid  input  1  write request
- wr_ready  output  1  block can accept a write this cycle
- wr_char  input  7  character to store at cursor (or NL_CHAR)
- wr_set_cursor  input  1  qualifies wr_valid: load cursor from wr_addr instead of writing
- wr_addr  input  8  new cursor value {row, col}
- clr_req  input  1  single-cycle pulse: clear whole buffer
- busy  output  1  high while clear FSM runs
- cursor  output  8  current cursor position (debug/status)

Behaviour:
- Single clock domain.
- Reset is asynchronous and active-low: rst=0 forces state=CLEAR, clr_ptr=0, cursor=0, busy=1. While rst=0, wr_ready=0 and char_code=CLEAR_CHAR.
- Storage: 256 x 7 memory, written synchronously. Read is asynchronous, with zero latency from char_xy to char_code; the drawer samples it in the same cycle, as with the ROM it replaces.
- FSM states: CLEAR, IDLE.
- CLEAR state:
  - Each cycle write CLEAR_CHAR to mem[clr_ptr], then clr_ptr<=clr_ptr+1.
  - When clr_ptr==8'hFF is written, go to IDLE next cycle. A full clear takes exactly 256 cycles.
  - busy=1, wr_ready=0.
  - char_code=CLEAR_CHAR regardless of char_xy, so stale cells are never displayed.
  - clr_req is ignored; the running clear is not restarted.
- IDLE state:
  - busy=0, wr_ready = !clr_req (combinational).
  - char_code=mem[char_xy].
- Write acceptance: a write is accepted on a rising edge where wr_valid && wr_ready.
  - wr_set_cursor=1: cursor<=wr_addr; memory unchanged.
  - wr_set_cursor=0, wr_char==NL_CHAR: cursor<={cursor[7:4]+1, 4'h0}; row 15 wraps to row 0; memory unchanged.
  - Otherwise: mem[cursor]<=wr_char, cursor<=cursor+1, wrapping 8'hFF->8'h00 modulo 256. Col 15 carries into the next row naturally.
  - A written value appears on char_code from the next cycle when char_xy==that address. No read-during-write bypass is required in the write cycle itself.
- clr_req in IDLE: next state CLEAR, clr_ptr<=0, cursor<=0. A simultaneous wr_valid is not accepted, because wr_ready is 0 that cycle.
- A wr_valid held while not ready must be held by the source; nothing is dropped or queued.
- rst asserted mid-clear or mid-write: immediate return to CLEAR, and the full 256-cycle clear restarts after release.

Test Plan:
- Release rst, hold wr_valid=1 -> busy=1 and wr_ready=0 for exactly 256 cycles, char_code=7'h20 for all char_xy; then busy=0, wr_ready=1, and a sweep of all 256 char_xy reads 7'h20.
- Set cursor to 8'h12 (wr_set_cursor=1), then write 'S','C','O','R','E' (7'h53,7'h43,7'h4F,7'h52,7'h45) back-to-back -> char_xy 8'h12..8'h16 return those codes, cursor=8'h17.
- Cursor 8'hFE, write 7'h41, 7'h42, 7'h43 -> mem[FE]=41, mem[FF]=42, mem[00]=43, cursor=8'h01 (wrap).
- Cursor 8'h35, write NL_CHAR -> cursor=8'h40, mem[35] unchanged. Cursor 8'hF7, write NL_CHAR -> cursor=8'h00.
- In IDLE with text present, pulse clr_req with wr_valid=1 in the same cycle -> write not accepted, busy=1 next cycle, 256-cycle clear, cursor=0, all cells 7'h20. A clr_req pulse mid-clear does not extend the clear beyond 256 cycles.
- Assert rst at clear cycle 100, release -> clear restarts at clr_ptr=0 and lasts a full 256 cycles; char_code=7'h20 throughout.
